hue_wheel_scheduler: RTL and testbench
======================================

Name: hue_wheel_scheduler

Overview:
Single-clock-domain controller that sequences the 6-stage HSV hue wheel: red→yellow→green→cyan→blue→magenta→red.
- Owns the step-rate divider, the per-stage round counter and the stage index.
- Updates the R/G/B duty registers that feed the downstream PWM comparators.
- Accepts run/pause/rate/rewind commands from a control master over a valid/ready handshake.
- Every counter advances on clk with enables. No derived clocks.

Parameters:
PWM_INTERVAL, 1200, full-scale duty value (PWM period in clk cycles); must be divisible by ROUNDS.
ROUNDS, 100, duty steps per stage; derived localparam STEP = PWM_INTERVAL/ROUNDS.
DIV_W, 16, width of step divider and cmd_data.
DEFAULT_DIV, 20000, clk cycles per duty step after reset.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command can be accepted this cycle
cmd_op  in  2  00 RUN, 01 PAUSE, 10 SET_DIV, 11 REWIND
cmd_data  in  DIV_W  new divider value, used by SET_DIV only
duty_r  out  $clog2(PWM_INTERVAL+1)  red duty
duty_g  out  $clog2(PWM_INTERVAL+1)  green duty
duty_b  out  $clog2(PWM_INTERVAL+1)  blue duty
stage  out  3  current stage 0..5
running  out  1  state == RUN
step_tick  out  1  one-cycle pulse on each duty update
wheel_done  out  1  one-cycle pulse when stage wraps 5→0

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; duty_r=PWM_INTERVAL, duty_g=0, duty_b=0.
  - stage=0, round_cnt=0, div_cnt=0.
  - div=DEFAULT_DIV, pending flag=0; all pulses 0.
  - cmd_ready=1 one cycle after deassertion.
- States: IDLE, RUN, PAUSED.
  - RUN from IDLE/PAUSED → RUN.
  - PAUSE from RUN → PAUSED; in IDLE/PAUSED it is a no-op.
  - REWIND from any state restores reset duties/stage/round_cnt/div_cnt; RUN stays RUN, PAUSED and IDLE → IDLE. div is kept.
  - SET_DIV does not change state.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready at the rising edge.
  - cmd_ready = !(pending && running), i.e. low only while a SET_DIV is pending in RUN.
- SET_DIV:
  - A value of 0 is stored as 1.
  - Not running: div takes the new value at the accept edge.
  - Running: value is held in pending_div and loaded on the next step_tick cycle; div_cnt restarts at 0 with the new div.
- Divider:
  - In RUN, div_cnt counts 0..div-1. step_tick is asserted for the cycle after div_cnt == div-1, so the first tick comes div cycles after entering RUN.
  - Not in RUN: div_cnt holds its value (PAUSE resumes mid-interval) and step_tick=0.
- On each step, by stage:
  - 0: G += STEP.
  - 1: R −= STEP.
  - 2: B += STEP.
  - 3: G −= STEP.
  - 4: R += STEP.
  - 5: B −= STEP.
  - Results saturate to [0, PWM_INTERVAL]; never wrap.
  - round_cnt increments. At ROUNDS−1 it wraps to 0 and stage increments. At stage 5 the stage wraps to 0 and wheel_done pulses in the same cycle as step_tick.
- Outputs are registered and change only on step or REWIND, so duty changes one cycle after the triggering tick condition.
- Simultaneous events:
  - REWIND beats a coincident step.
  - PAUSE accepted on a step cycle: the step still completes.
  - SET_DIV pending and a step on the same cycle: the step uses the old div, then the new div is loaded.
- Invariant: at every stage boundary the duties are exact primaries/secondaries (e.g. after stage 0: R=G=PWM_INTERVAL, B=0).
- Reset asserted mid-operation clears everything immediately, including the pending SET_DIV.

Test Plan:
1. PWM_INTERVAL=12, ROUNDS=4, DEFAULT_DIV=2; release reset, RUN → step_tick every 2 cycles; duty_g 0,3,6,9,12; stage=1 after the 4th tick.
2. Same params, run 24 ticks → stage sequence 0..5 then 0; wheel_done exactly once, coincident with the 24th tick; duties back to R=12, G=0, B=0.
3. RUN, PAUSE after 3 cycles, wait 10, RUN → no ticks while paused; next tick 1 cycle after resume (div_cnt held at 1).
4. In RUN, SET_DIV 5 then immediately SET_DIV 7 → cmd_ready=0 until the next tick; afterwards tick spacing is 5; the second command is accepted at that tick and spacing becomes 7 from the following tick.
5. REWIND on the same cycle as a step in stage 2 → duties 12/0/0, stage 0, state stays RUN, no step applied.
6. SET_DIV 0 while IDLE, then RUN → step_tick every cycle; assert rst_n low mid-stage 3 → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/hue_wheel_scheduler.sv
// Hue wheel scheduler: walks the R/G/B duty registers around the six-stage HSV
// wheel at a programmable step rate, under run/pause/rate/rewind commands.
module hue_wheel_scheduler #(
   parameter int  PWM_INTERVAL = 1200,
   parameter int  ROUNDS       = 100,
   parameter int  DIV_W        = 16,
   parameter int  DEFAULT_DIV  = 20000,
   localparam int DUTY_W       = $clog2(PWM_INTERVAL + 1)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [1:0]        cmd_op_i,
   input  logic [DIV_W-1:0]  cmd_data_i,
   output logic [DUTY_W-1:0] duty_r_o,
   output logic [DUTY_W-1:0] duty_g_o,
   output logic [DUTY_W-1:0] duty_b_o,
   output logic [2:0]        stage_o,
   output logic              running_o,
   output logic              step_tick_o,
   output logic              wheel_done_o
);
   // state    | meaning
   // S_IDLE   | parked at the red start point, divider stopped
   // S_RUN    | divider counting, duties stepping on each terminal count
   // S_PAUSED | divider frozen mid-interval, duties held

   localparam int STEP    = PWM_INTERVAL / ROUNDS;
   localparam int ROUND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

   localparam logic [1:0] OP_RUN     = 2'b00;
   localparam logic [1:0] OP_PAUSE   = 2'b01;
   localparam logic [1:0] OP_SET_DIV = 2'b10;
   localparam logic [1:0] OP_REWIND  = 2'b11;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSED = 2'd2} state_t;

   state_t             state_q, state_d;
   logic               ready_q;
   logic [DUTY_W-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
   logic [2:0]         stage_q, stage_d;
   logic [ROUND_W-1:0] round_q, round_d;
   logic [DIV_W-1:0]   div_q, div_d, div_cnt_q, div_cnt_d, pend_div_q, pend_div_d;
   logic [DIV_W-1:0]   set_val;
   logic               pend_q, pend_d, tick_q, tick_d, done_q, done_d;
   logic               run_st, accept, step, rewind;

   function automatic logic [DUTY_W-1:0] sat_add(input logic [DUTY_W-1:0] v);
      logic [DUTY_W:0] s;
      s = {1'b0, v} + (DUTY_W+1)'(STEP);
      if (s > (DUTY_W+1)'(PWM_INTERVAL)) return DUTY_W'(PWM_INTERVAL);
      return s[DUTY_W-1:0];
   endfunction

   function automatic logic [DUTY_W-1:0] sat_sub(input logic [DUTY_W-1:0] v);
      if (v < DUTY_W'(STEP)) return '0;
      return v - DUTY_W'(STEP);
   endfunction

   assign run_st  = (state_q == S_RUN);
   assign accept  = cmd_valid_i && cmd_ready_o;
   assign rewind  = accept && (cmd_op_i == OP_REWIND);
   assign step    = run_st && (div_cnt_q == div_q - DIV_W'(1));
   assign set_val = (cmd_data_i == '0) ? DIV_W'(1) : cmd_data_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         case (cmd_op_i)
            OP_RUN:    state_d = S_RUN;
            OP_PAUSE:  if (run_st) state_d = S_PAUSED;
            OP_REWIND: state_d = run_st ? S_RUN : S_IDLE;
            default:   state_d = state_q;
         endcase
      end
   end

   always_comb begin
      running_o   = run_st;
      cmd_ready_o = ready_q && !(pend_q && run_st);
   end

   always_comb begin
      r_d        = r_q;
      g_d        = g_q;
      b_d        = b_q;
      stage_d    = stage_q;
      round_d    = round_q;
      div_d      = div_q;
      div_cnt_d  = div_cnt_q;
      pend_d     = pend_q;
      pend_div_d = pend_div_q;
      tick_d     = 1'b0;
      done_d     = 1'b0;
      if (rewind) begin
         r_d       = DUTY_W'(PWM_INTERVAL);
         g_d       = '0;
         b_d       = '0;
         stage_d   = '0;
         round_d   = '0;
         div_cnt_d = '0;
      end else if (step) begin
         tick_d    = 1'b1;
         div_cnt_d = '0;
         case (stage_q)
            3'd0:    g_d = sat_add(g_q);
            3'd1:    r_d = sat_sub(r_q);
            3'd2:    b_d = sat_add(b_q);
            3'd3:    g_d = sat_sub(g_q);
            3'd4:    r_d = sat_add(r_q);
            default: b_d = sat_sub(b_q);
         endcase
         if (round_q == ROUND_W'(ROUNDS - 1)) begin
            round_d = '0;
            if (stage_q == 3'd5) begin
               stage_d = '0;
               done_d  = 1'b1;
            end else begin
               stage_d = stage_q + 3'd1;
            end
         end else begin
            round_d = round_q + ROUND_W'(1);
         end
         // a rate change requested while running takes effect only after this step
         if (pend_q) begin
            div_d  = pend_div_q;
            pend_d = 1'b0;
         end
      end else if (run_st) begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
      end
      if (accept && (cmd_op_i == OP_SET_DIV)) begin
         if (run_st) begin
            pend_d     = 1'b1;
            pend_div_d = set_val;
         end else begin
            div_d = set_val;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ready_q    <= 1'b0;
         r_q        <= DUTY_W'(PWM_INTERVAL);
         g_q        <= '0;
         b_q        <= '0;
         stage_q    <= '0;
         round_q    <= '0;
         div_q      <= DIV_W'(DEFAULT_DIV);
         div_cnt_q  <= '0;
         pend_q     <= 1'b0;
         pend_div_q <= '0;
         tick_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         ready_q    <= 1'b1;
         r_q        <= r_d;
         g_q        <= g_d;
         b_q        <= b_d;
         stage_q    <= stage_d;
         round_q    <= round_d;
         div_q      <= div_d;
         div_cnt_q  <= div_cnt_d;
         pend_q     <= pend_d;
         pend_div_q <= pend_div_d;
         tick_q     <= tick_d;
         done_q     <= done_d;
      end
   end

   assign duty_r_o     = r_q;
   assign duty_g_o     = g_q;
   assign duty_b_o     = b_q;
   assign stage_o      = stage_q;
   assign step_tick_o  = tick_q;
   assign wheel_done_o = done_q;

endmodule

// File: tb/tb_hue_wheel_scheduler.sv
// Directed bench for hue_wheel_scheduler with a small wheel (12 / 4 rounds / div 2)
// so stage boundaries and command interactions can be hand-computed.
module tb_hue_wheel_scheduler;
   localparam int PWM = 12, RND = 4, DW = 16, DDIV = 2, W = 4;

   localparam logic [1:0] OP_RUN = 2'b00, OP_PAUSE = 2'b01, OP_SET = 2'b10, OP_REW = 2'b11;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready;
   logic [1:0]    cmd_op;
   logic [DW-1:0] cmd_data;
   logic [W-1:0]  duty_r, duty_g, duty_b;
   logic [2:0]    stage;
   logic          running, step_tick, wheel_done;

   int n_tests = 0, n_fail = 0;
   int cyc = 0, done_cnt = 0, done_alone = 0;
   int prev, t1, seen_paused;

   always #5 clk = ~clk;

   hue_wheel_scheduler #(
      .PWM_INTERVAL(PWM), .ROUNDS(RND), .DIV_W(DW), .DEFAULT_DIV(DDIV)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_op_i(cmd_op), .cmd_data_i(cmd_data),
      .duty_r_o(duty_r), .duty_g_o(duty_g), .duty_b_o(duty_b),
      .stage_o(stage), .running_o(running),
      .step_tick_o(step_tick), .wheel_done_o(wheel_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rgb(input string tag, input int r, input int g, input int b);
      chk({tag, "_r"}, duty_r, r);
      chk({tag, "_g"}, duty_g, g);
      chk({tag, "_b"}, duty_b, b);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (wheel_done === 1'b1) begin
         done_cnt++;
         if (step_tick !== 1'b1) done_alone++;
      end
   endtask

   task automatic wait_tick(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (step_tick === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, "_seen"}, seen, 1);
   endtask

   task automatic send(input logic [1:0] op, input logic [DW-1:0] data);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      for (int i = 0; i < 40 && cmd_ready !== 1'b1; i++) step();
      chk("send_ready", cmd_ready, 1);
      step();
      cmd_valid = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = OP_RUN;
      cmd_data  = '0;
      #1 rst_n = 1'b0;
      #2;
      chk_rgb("rst", 12, 0, 0);
      chk("rst_stage", stage, 0);
      chk("rst_running", running, 0);
      chk("rst_tick", step_tick, 0);
      chk("rst_done", wheel_done, 0);
      chk("rst_ready", cmd_ready, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      chk("ready_after_rst", cmd_ready, 1);

      // one full wheel at div 2
      send(OP_RUN, '0);
      chk("run_state", running, 1);
      prev = cyc;
      for (int k = 1; k <= 24; k++) begin
         wait_tick("wheel");
         chk("wheel_spacing", cyc - prev, 2);
         prev = cyc;
         if (k <= 4) chk("g_ramp", duty_g, 3 * k);
         chk("wheel_stage", stage, (k / 4) % 6);
         case (k)
            4:  chk_rgb("yellow", 12, 12, 0);
            8:  chk_rgb("green", 0, 12, 0);
            12: chk_rgb("cyan", 0, 12, 12);
            16: chk_rgb("blue", 0, 0, 12);
            20: begin
               chk_rgb("magenta", 12, 0, 12);
               chk("no_done_yet", done_cnt, 0);
            end
            24: begin
               chk_rgb("red_again", 12, 0, 0);
               chk("done_at_24", wheel_done, 1);
               chk("done_count", done_cnt, 1);
               chk("done_alone", done_alone, 0);
            end
            default: ;
         endcase
      end

      // pause right after a tick holds div_cnt at 1
      cmd_valid = 1'b1; cmd_op = OP_PAUSE;
      step();
      cmd_valid = 1'b0;
      chk("paused", running, 0);
      seen_paused = 0;
      repeat (10) begin
         step();
         if (step_tick === 1'b1) seen_paused++;
      end
      chk("no_tick_paused", seen_paused, 0);
      chk("paused_g", duty_g, 0);
      send(OP_RUN, '0);
      prev = cyc;
      wait_tick("resume");
      chk("resume_spacing", cyc - prev, 1);
      chk("resume_g", duty_g, 3);

      // pause landing on a step cycle still completes that step
      step();
      cmd_valid = 1'b1; cmd_op = OP_PAUSE;
      step();
      cmd_valid = 1'b0;
      chk("pause_step_tick", step_tick, 1);
      chk("pause_step_run", running, 0);
      chk("pause_step_g", duty_g, 6);
      send(OP_RUN, '0);
      prev = cyc;
      wait_tick("resume2");
      chk("resume2_spacing", cyc - prev, 2);
      chk("resume2_g", duty_g, 9);

      // back-to-back SET_DIV while running
      cmd_valid = 1'b1; cmd_op = OP_SET; cmd_data = 16'd5;
      step();
      chk("ready_pending", cmd_ready, 0);
      chk("no_tick_yet", step_tick, 0);
      cmd_data = 16'd7;
      step();
      chk("load_tick", step_tick, 1);
      chk("ready_after_load", cmd_ready, 1);
      chk("load_g", duty_g, 12);
      chk("load_stage", stage, 1);
      t1 = cyc;
      step();
      cmd_valid = 1'b0;
      chk("ready_pending2", cmd_ready, 0);
      wait_tick("div5");
      chk("div5_spacing", cyc - t1, 5);
      chk("div5_r", duty_r, 9);
      prev = cyc;
      wait_tick("div7");
      chk("div7_spacing", cyc - prev, 7);
      chk("div7_r", duty_r, 6);
      wait_tick("to_st2a");
      wait_tick("to_st2b");
      chk("st2_stage", stage, 2);
      chk_rgb("st2", 0, 12, 0);

      // REWIND coinciding with the first stage-2 step
      repeat (6) step();
      cmd_valid = 1'b1; cmd_op = OP_REW;
      step();
      cmd_valid = 1'b0;
      chk("rew_tick", step_tick, 0);
      chk("rew_stage", stage, 0);
      chk("rew_running", running, 1);
      chk_rgb("rew", 12, 0, 0);
      prev = cyc;
      wait_tick("after_rew");
      chk("after_rew_spacing", cyc - prev, 7);
      chk("after_rew_g", duty_g, 3);

      // SET_DIV 0 while idle, then async reset mid stage 3
      send(OP_PAUSE, '0);
      chk("p6_paused", running, 0);
      send(OP_REW, '0);
      chk("rew_to_idle", running, 0);
      chk_rgb("idle_rew", 12, 0, 0);
      send(OP_SET, 16'd0);
      send(OP_RUN, '0);
      prev = cyc;
      for (int k = 1; k <= 14; k++) begin
         wait_tick("div1");
         chk("div1_spacing", cyc - prev, 1);
         prev = cyc;
      end
      chk("mid_st3_stage", stage, 3);
      chk_rgb("mid_st3", 0, 6, 12);
      #2 rst_n = 1'b0;
      #1;
      chk_rgb("async_rst", 12, 0, 0);
      chk("async_stage", stage, 0);
      chk("async_running", running, 0);
      chk("async_tick", step_tick, 0);
      chk("async_ready", cmd_ready, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      send(OP_RUN, '0);
      prev = cyc;
      wait_tick("post_rst");
      chk("post_rst_div_default", cyc - prev, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
